// File: rtl/mod_counter_ctrl_pkg.sv
// Shared definitions for the mod-N counter sequencer: FSM state encoding and
// direction constants.
package mod_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter_ctrl_updown_mod_core.sv
// Runtime-modulus up/down counter with synchronous load and enable; count is
// registered, wrap_o flags (combinationally) that the enabled step wraps.
module updown_mod_core
  import mod_counter_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         dir_i,
  input  logic [W:0]   mod_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] top_w;
  logic         at_edge;

  // mod_i[W] set means N = 2^W, whose last value is all ones.
  assign top_w   = mod_i[W] ? '1 : (mod_i[W-1:0] - W'(1));
  assign at_edge = (dir_i == DIR_UP) ? (count_q == top_w) : (count_q == '0);
  assign wrap_o  = en_i && at_edge;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (dir_i == DIR_UP) count_d = at_edge ? '0 : (count_q + W'(1));
      else                 count_d = at_edge ? top_w : (count_q - W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/mod_counter_ctrl.sv
// Command-driven sequencer running a mod-N up/down counter for a programmed step
// count; done pulses S+1 cycles after accept, commands accepted only while idle.
module mod_counter_ctrl
  import mod_counter_ctrl_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_dir,
  input  logic [W-1:0]  cmd_mod,
  input  logic [W-1:0]  cmd_start,
  input  logic [CW-1:0] cmd_steps,
  input  logic          pause,
  input  logic          abort,
  output logic [W-1:0]  count,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] wraps
);

  state_e        state_q;
  logic          dir_q;
  logic [W:0]    mod_q;
  logic [CW-1:0] rem_q;
  logic [CW-1:0] wraps_q;
  logic          done_q, busy_q, ready_q;

  logic [W:0]    n_eff;
  logic [W-1:0]  start_eff;
  logic          accept, step_en, core_wrap;

  // Modulus encoding: 0 means 2^W, 1 is promoted to 2.
  always_comb begin
    n_eff = {1'b0, cmd_mod};
    if (cmd_mod == '0)            n_eff = {1'b1, {W{1'b0}}};
    else if (cmd_mod == W'(1))    n_eff = (W+1)'(2);
  end

  assign start_eff = ({1'b0, cmd_start} >= n_eff) ? '0 : cmd_start;
  assign accept    = cmd_valid && ready_q;
  assign step_en   = (state_q == ST_RUN) && !abort && !pause;

  updown_mod_core #(.W(W)) u_core (
    .clk        (clk),
    .rst        (reset),
    .load_i     (accept),
    .load_val_i (start_eff),
    .en_i       (step_en),
    .dir_i      (dir_q),
    .mod_i      (mod_q),
    .count_o    (count),
    .wrap_o     (core_wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      mod_q   <= '0;
      rem_q   <= '0;
      wraps_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            dir_q   <= cmd_dir;
            mod_q   <= n_eff;
            rem_q   <= cmd_steps;
            wraps_q <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            if (cmd_steps != '0) begin
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (!pause) begin
            rem_q <= rem_q - CW'(1);
            if (core_wrap && (wraps_q != '1)) wraps_q <= wraps_q + CW'(1);
            if (rem_q == CW'(1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wraps     = wraps_q;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed bench for mod_counter_ctrl: hand-computed vectors checked with
// immediate assertions after each clock edge.
module tb_mod_counter_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [W-1:0]  cmd_mod;
  logic [W-1:0]  cmd_start;
  logic [CW-1:0] cmd_steps;
  logic          pause;
  logic          abort;
  logic [W-1:0]  count;
  logic          busy;
  logic          done;
  logic [CW-1:0] wraps;

  int checks = 0;
  int errors = 0;

  mod_counter_ctrl #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_mod   (cmd_mod),
    .cmd_start (cmd_start),
    .cmd_steps (cmd_steps),
    .pause     (pause),
    .abort     (abort),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .wraps     (wraps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one accept edge.
  task automatic send(input logic dir, input int m, input int st, input int steps);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_mod   = W'(m);
    cmd_start = W'(st);
    cmd_steps = CW'(steps);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int exp_up[5];
    int exp_dn[3];
    int n;

    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_mod = '0;
    cmd_start = '0; cmd_steps = '0; pause = 1'b0; abort = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_done",  32'(done), 0);
    chk("rst_wraps", 32'(wraps), 0);
    tick();
    reset = 1'b0;
    tick();

    // 1: up, N=10, start 7, 5 steps
    exp_up = '{8, 9, 0, 1, 2};
    send(1'b1, 10, 7, 5);
    chk("t1_load",  32'(count), 7);
    chk("t1_busy",  32'(busy), 1);
    chk("t1_ready", 32'(cmd_ready), 0);
    for (int i = 0; i < 5; i++) begin
      chk("t1_done_early", 32'(done), 0);
      tick();
      chk($sformatf("t1_step%0d", i), 32'(count), 32'(exp_up[i]));
    end
    chk("t1_done",  32'(done), 1);
    chk("t1_wraps", 32'(wraps), 1);
    tick();
    chk("t1_done_1cyc", 32'(done), 0);
    chk("t1_hold",      32'(count), 2);
    chk("t1_ready_end", 32'(cmd_ready), 1);
    chk("t1_busy_end",  32'(busy), 0);

    // 2: down, N=10, start 1, 3 steps
    exp_dn = '{0, 9, 8};
    send(1'b0, 10, 1, 3);
    chk("t2_load", 32'(count), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t2_step%0d", i), 32'(count), 32'(exp_dn[i]));
    end
    chk("t2_done",  32'(done), 1);
    chk("t2_wraps", 32'(wraps), 1);
    tick();
    chk("t2_ready", 32'(cmd_ready), 1);

    // 3: pause for 3 cycles after step 2; a command during RUN is ignored
    send(1'b1, 10, 0, 5);
    n = 0;
    tick(); n++;
    tick(); n++;
    chk("t3_pre_pause", 32'(count), 2);
    pause = 1'b1;
    cmd_valid = 1'b1; cmd_start = W'(6); cmd_steps = CW'(1);
    for (int i = 0; i < 3; i++) begin
      tick(); n++;
      chk($sformatf("t3_frozen%0d", i), 32'(count), 2);
      chk("t3_no_ready", 32'(cmd_ready), 0);
    end
    pause = 1'b0;
    cmd_valid = 1'b0;
    while (!done && n < 20) begin
      tick(); n++;
    end
    chk("t3_done_seen", 32'(done), 1);
    chk("t3_done_cycle", 32'(n + 1), 9);
    chk("t3_final", 32'(count), 5);
    chk("t3_wraps", 32'(wraps), 0);
    tick();

    // 4: abort beats pause after step 2
    send(1'b1, 10, 0, 10);
    tick();
    tick();
    abort = 1'b1; pause = 1'b1;
    tick();
    chk("t4_busy",  32'(busy), 0);
    chk("t4_ready", 32'(cmd_ready), 1);
    chk("t4_count", 32'(count), 2);
    chk("t4_done",  32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_idle_hold", 32'(count), 2);
      chk("t4_no_done",   32'(done), 0);
    end
    abort = 1'b0; pause = 1'b0;

    // 5: zero-step commands and start/modulus clamping
    send(1'b1, 10, 4, 0);
    chk("t5_count", 32'(count), 4);
    chk("t5_done",  32'(done), 1);
    chk("t5_busy",  32'(busy), 1);
    tick();
    chk("t5_done_off", 32'(done), 0);
    chk("t5_ready",    32'(cmd_ready), 1);
    send(1'b1, 10, 12, 0);
    chk("t5_start_clamp", 32'(count), 0);
    tick();
    send(1'b1, 1, 1, 1);
    chk("t5_mod1_load", 32'(count), 1);
    tick();
    chk("t5_mod1_wrap",  32'(count), 0);
    chk("t5_mod1_wraps", 32'(wraps), 1);
    tick();

    // 6: async reset mid-run, then N=2^W wrap
    send(1'b1, 10, 3, 20);
    tick();
    tick();
    chk("t6_running", 32'(count), 5);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_busy",  32'(busy), 0);
    chk("t6_rst_ready", 32'(cmd_ready), 1);
    chk("t6_rst_done",  32'(done), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_no_done", 32'(done), 0);
    send(1'b1, 0, 15, 2);
    chk("t6_load15", 32'(count), 15);
    tick();
    chk("t6_wrap0",  32'(count), 0);
    tick();
    chk("t6_step1",  32'(count), 1);
    chk("t6_wraps",  32'(wraps), 1);
    chk("t6_done",   32'(done), 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
